ahb_rr_arbiter: RTL



---
 rtl/ahb_rr_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB arbiter with lock, park master and optional tenure limit (AHB_ARB_TENURE_LIMIT_EN)
module ahb_rr_arbiter #(
    parameter int NMASTERS    = 4,
    parameter int MAX_TENURE  = 8,
    parameter int PARK_MASTER = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NMASTERS-1:0] HBUSREQx,
    input  logic [NMASTERS-1:0] HLOCKx,
    input  logic                HREADY,
    output logic [NMASTERS-1:0] HGRANTx,
    output logic [3:0]          HMASTER,
    output logic                HMASTLOCK,
    output logic                tenure_expired
);

    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    localparam logic [0:0] ST_PARK = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [IW-1:0]       PARK_IDX    = IW'(PARK_MASTER);
    localparam logic [NMASTERS-1:0] ONE         = {{(NMASTERS-1){1'b0}}, 1'b1};
    localparam logic [NMASTERS-1:0] PARK_GRANT  = ONE << PARK_MASTER;

    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]       own_q, own_d;
    logic [0:0]          state_q, state_d;
    logic [3:0]          hmaster_q, hmaster_d;
    logic                hmastlock_q, hmastlock_d;

    logic                own_req;
    logic                own_lock;
    logic                others_req;
    logic                keep_ok;
    logic [IW-1:0]       rot_idx;
    logic                expire;

    assign own_req    = HBUSREQx[own_q];
    assign own_lock   = HLOCKx[own_q];
    // grant_q is one-hot on own_q, so masking with it removes the owner
    assign others_req = |(HBUSREQx & ~grant_q);

`ifdef AHB_ARB_TENURE_LIMIT_EN
    localparam logic [7:0] MAX_T = 8'(MAX_TENURE);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       te_q;

    assign cnt_inc = (cnt_q >= MAX_T) ? MAX_T : cnt_q + 8'd1;
    // An unlocked owner may stay past its tenure only if nobody else is waiting
    assign keep_ok = (cnt_q < MAX_T) || !others_req;
`else
    // Parameter kept so both builds share one instantiation signature
    logic [7:0] unused_max_tenure;
    assign unused_max_tenure = 8'(MAX_TENURE);
    assign keep_ok = 1'b1;
`endif

    // First requester after the owner in rotation order; the owner itself is never a candidate
    always_comb begin
        rot_idx = own_q;
        for (int d = NMASTERS - 1; d >= 1; d--) begin
            int j;
            j = int'(own_q) + d;
            if (j >= NMASTERS) j = j - NMASTERS;
            if (HBUSREQx[IW'(j)]) rot_idx = IW'(j);
        end
    end

    // Ownership decision; only takes effect on an HREADY-high edge
    always_comb begin
        grant_d     = grant_q;
        own_d       = own_q;
        state_d     = state_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        expire      = 1'b0;
`ifdef AHB_ARB_TENURE_LIMIT_EN
        cnt_d       = cnt_q;
`endif
        if (HREADY) begin
            hmaster_d   = 4'(own_q);
            hmastlock_d = own_lock;
            if (own_req && (own_lock || keep_ok)) begin
                state_d = ST_OWN;
`ifdef AHB_ARB_TENURE_LIMIT_EN
                cnt_d   = cnt_inc;
`endif
            end else if (others_req) begin
                own_d   = rot_idx;
                grant_d = ONE << rot_idx;
                state_d = ST_OWN;
                expire  = own_req;
`ifdef AHB_ARB_TENURE_LIMIT_EN
                cnt_d   = 8'd0;
`endif
            end else begin
                own_d   = PARK_IDX;
                grant_d = PARK_GRANT;
                state_d = ST_PARK;
`ifdef AHB_ARB_TENURE_LIMIT_EN
                cnt_d   = 8'd0;
`endif
            end
        end
    end

    // Arbitration state; everything freezes while HREADY is low
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q     <= PARK_GRANT;
            own_q       <= PARK_IDX;
            state_q     <= ST_PARK;
            hmaster_q   <= 4'(PARK_MASTER);
            hmastlock_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            own_q       <= own_d;
            state_q     <= state_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

`ifdef AHB_ARB_TENURE_LIMIT_EN
    // Tenure counter and the one-cycle preemption pulse
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_q <= 8'd0;
            te_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            te_q  <= expire;
        end
    end

    assign tenure_expired = te_q;
`else
    logic unused_expire;
    assign unused_expire  = expire;
    assign tenure_expired = 1'b0;
`endif

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
